// File: rtl/adsr_envelope.sv
// ADSR envelope generator with a registered amplitude-scaling output stage.
// Optional feature: define ENV_RETRIGGER_EN to let a new gate restart ATTACK from RELEASE.
module adsr_envelope #(
    parameter int W = 8,
    parameter int ENV_W = 8,
    parameter logic [ENV_W-1:0] ATTACK_STEP   = ENV_W'(64),
    parameter logic [ENV_W-1:0] DECAY_STEP    = ENV_W'(32),
    parameter logic [ENV_W-1:0] SUSTAIN_LEVEL = ENV_W'(128),
    parameter logic [ENV_W-1:0] RELEASE_STEP  = ENV_W'(16)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gate,
    input  logic             sample_tick,
    input  logic [W-1:0]     audio_in,
    output logic [W-1:0]     audio_out,
    output logic [ENV_W-1:0] level_out,
    output logic [2:0]       state_out,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    localparam logic [ENV_W-1:0] LMAX = {ENV_W{1'b1}};
    localparam logic [W-1:0]     MID  = {1'b1, {(W-1){1'b0}}};

    // Saturating add clamped at LMAX, using an ENV_W+1-bit intermediate.
    function automatic logic [ENV_W-1:0] sat_add(input logic [ENV_W-1:0] a, input logic [ENV_W-1:0] b);
        logic [ENV_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[ENV_W] ? LMAX : sum[ENV_W-1:0];
    endfunction

    // Subtract with a lower clamp; the comparison happens before the subtraction so nothing wraps.
    function automatic logic [ENV_W-1:0] sat_sub(input logic [ENV_W-1:0] a, input logic [ENV_W-1:0] b,
                                                 input logic [ENV_W-1:0] floor_lvl);
        logic [ENV_W:0] limit;
        logic [ENV_W:0] diff;
        limit = {1'b0, b} + {1'b0, floor_lvl};
        diff  = {1'b0, a} - {1'b0, b};
        return ({1'b0, a} < limit) ? floor_lvl : diff[ENV_W-1:0];
    endfunction

    // Signed scaling of the offset-binary sample about the midpoint; floor via arithmetic shift.
    function automatic logic [W-1:0] scale_sample(input logic [W-1:0] a, input logic [ENV_W-1:0] lvl);
        logic signed [W:0]         s;
        logic signed [ENV_W:0]     l;
        logic signed [W+ENV_W+1:0] p;
        logic signed [W+ENV_W+1:0] q;
        s = $signed({1'b0, a}) - $signed({1'b0, MID});
        l = $signed({1'b0, lvl});
        p = (W+ENV_W+2)'(s) * (W+ENV_W+2)'(l);
        q = p >>> ENV_W;
        return W'(q) + MID;
    endfunction

    state_t            state;
    logic [ENV_W-1:0]  level;
    logic [W-1:0]      audio_p1;
    logic [ENV_W-1:0]  att_lvl;
    logic [ENV_W-1:0]  dec_lvl;
    logic [ENV_W-1:0]  rel_lvl;

    always_comb begin
        att_lvl = sat_add(level, ATTACK_STEP);
        dec_lvl = sat_sub(level, DECAY_STEP, SUSTAIN_LEVEL);
        rel_lvl = sat_sub(level, RELEASE_STEP, '0);
    end

    // Stage p1: envelope state/level update and registered scaled sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            level    <= '0;
            audio_p1 <= MID;
        end else begin
            audio_p1 <= scale_sample(audio_in, level);
            case (state)
                S_IDLE: begin
                    level <= '0;
                    if (gate) state <= S_ATTACK;
                end
                S_ATTACK: begin
                    if (!gate) begin
                        state <= S_RELEASE;
                    end else if (sample_tick) begin
                        level <= att_lvl;
                        if (att_lvl == LMAX) state <= S_DECAY;
                    end
                end
                S_DECAY: begin
                    if (!gate) begin
                        state <= S_RELEASE;
                    end else if (sample_tick) begin
                        level <= dec_lvl;
                        if (dec_lvl == SUSTAIN_LEVEL) state <= S_SUSTAIN;
                    end
                end
                S_SUSTAIN: begin
                    if (!gate) state <= S_RELEASE;
                end
                S_RELEASE: begin
`ifdef ENV_RETRIGGER_EN
                    if (gate) begin
                        state <= S_ATTACK;
                    end else if (sample_tick) begin
                        level <= rel_lvl;
                        if (rel_lvl == '0) state <= S_IDLE;
                    end
`else
                    if (sample_tick) begin
                        level <= rel_lvl;
                        if (rel_lvl == '0) state <= S_IDLE;
                    end
`endif
                end
                default: begin
                    state <= S_IDLE;
                    level <= '0;
                end
            endcase
        end
    end

    assign audio_out = audio_p1;
    assign level_out = level;
    assign state_out = state;
    assign busy      = (state != S_IDLE);

endmodule
